// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Brief    : Shared state encoding and default width for the EX-stage divider.
//  Revision : 1.0
// ============================================================================
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } divState_e;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Brief    : One combinational radix-2 restoring iteration on {rem, quo}.
//  Revision : 1.0
// ============================================================================
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shiftRem;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  always_comb begin
    // The shifted remainder needs WIDTH+1 bits; the stored one is always below the divisor.
    w_shiftRem = {i_rem, i_quo[WIDTH-1]};
    w_fits     = (w_shiftRem >= {1'b0, i_divisor});
    w_diff     = w_shiftRem[WIDTH-1:0] - i_divisor;
    o_rem      = w_fits ? w_diff : w_shiftRem[WIDTH-1:0];
    o_quo      = {i_quo[WIDTH-2:0], w_fits};
  end

endmodule : div_step
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_ctrl
//  Brief    : Iterative DIV/DIVU controller; stalls EX and returns {rem, quo}.
//  Revision : 1.0
// ============================================================================
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               annul_i,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               busy_o
);

  localparam int                c_cntW      = $clog2(WIDTH);
  localparam logic [c_cntW-1:0] c_lastCount = c_cntW'(WIDTH - 1);
  localparam logic [c_cntW-1:0] c_cntOne    = c_cntW'(1);

  divState_e          r_state;
  divState_e          w_stateNext;
  logic [c_cntW-1:0]  r_count;
  logic               r_signed;
  logic               r_signA;
  logic               r_signB;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept;
  logic               w_finish;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH-1:0]   w_stepRem;
  logic [WIDTH-1:0]   w_stepQuo;
  logic [WIDTH-1:0]   w_remFix;
  logic [WIDTH-1:0]   w_quoFix;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_divisor(r_divisor),
    .o_rem    (w_stepRem),
    .o_quo    (w_stepQuo)
  );

  always_comb begin
    w_absA   = (signed_i & a_i[WIDTH-1]) ? -a_i : a_i;
    w_absB   = (signed_i & b_i[WIDTH-1]) ? -b_i : b_i;
    w_quoFix = (r_signed & (r_signA ^ r_signB)) ? -w_stepQuo : w_stepQuo;
    w_remFix = (r_signed & r_signA) ? -w_stepRem : w_stepRem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    stall_o     = 1'b0;
    ready_o     = 1'b0;
    busy_o      = 1'b0;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = start_i & ~annul_i;
        stall_o  = w_accept;
        if (w_accept) begin
          w_stateNext = (b_i == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        busy_o = 1'b1;
        if (annul_i) begin
          w_stateNext = IDLE;
        end else begin
          stall_o = 1'b1;
          if (r_count == c_lastCount) begin
            w_finish    = 1'b1;
            w_stateNext = DONE;
          end
        end
      end
      DONE: begin
        busy_o      = 1'b1;
        ready_o     = ~annul_i;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_signed  <= 1'b0;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_signed  <= signed_i;
      r_signA   <= a_i[WIDTH-1];
      r_signB   <= b_i[WIDTH-1];
      r_quo     <= w_absA;
      r_divisor <= w_absB;
      r_rem     <= '0;
      r_count   <= '0;
      // Divide by zero bypasses the iteration and publishes the raw dividend.
      if (b_i == '0) begin
        r_result <= {a_i, {WIDTH{1'b1}}};
      end
    end else if ((r_state == BUSY) && !annul_i) begin
      r_rem   <= w_stepRem;
      r_quo   <= w_stepQuo;
      r_count <= r_count + c_cntOne;
      if (w_finish) begin
        r_result <= {w_remFix, w_quoFix};
      end
    end
  end

  assign result_o = r_result;

endmodule : div_ctrl
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_ctrl
//  Brief    : Directed and random checks of div_ctrl against a behavioural model.
//  Revision : 1.0
// ============================================================================
module tb_div_ctrl;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           signed_i;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           annul_i;
  logic           stall_o;
  logic           ready_o;
  logic [2*W-1:0] result_o;
  logic           busy_o;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .signed_i(signed_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .annul_i (annul_i),
    .stall_o (stall_o),
    .ready_o (ready_o),
    .result_o(result_o),
    .busy_o  (busy_o)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: an operation in flight, the cycle its result is due, and the held result.
  bit          mPending = 1'b0;
  int          mDoneCyc = 0;
  logic [63:0] mExp     = '0;
  logic [63:0] mLast    = '0;

  int          sCyc;
  bit          sReady, sStall, sBusy;
  logic [63:0] sRes;

  function automatic logic [63:0] refDiv(bit s, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit eBusy, eReady, eStall;
    @(negedge clk);
    if (!mPending) begin
      eBusy = 0; eReady = 0; eStall = start_i & ~annul_i;
    end else if (cyc < mDoneCyc) begin
      eBusy = 1; eReady = 0; eStall = ~annul_i;
    end else begin
      eBusy = 1; eReady = ~annul_i; eStall = 0;
    end
    check("stall_o", 64'(stall_o), 64'(eStall));
    check("ready_o", 64'(ready_o), 64'(eReady));
    check("busy_o", 64'(busy_o), 64'(eBusy));
    check("result_o", result_o, mLast);
    sCyc = cyc; sReady = ready_o; sStall = stall_o; sBusy = busy_o; sRes = result_o;
    @(posedge clk);
    if (rst) begin
      mPending = 0;
      mLast    = '0;
    end else begin
      if (mPending) begin
        if (annul_i || cyc == mDoneCyc) mPending = 0;
      end else if (start_i && !annul_i) begin
        mPending = 1;
        mExp     = refDiv(signed_i, a_i, b_i);
        mDoneCyc = cyc + ((b_i == 0) ? 1 : W + 1);
      end
      if (mPending && mDoneCyc == cyc + 1) mLast = mExp;
    end
    cyc++;
    #1;
  endtask

  task automatic runOp(string name, bit s, logic [31:0] a, logic [31:0] b,
                       logic [63:0] expRes, int expLat, bit hold);
    int t;
    int stallCnt;
    bit seen;
    stallCnt = 0;
    seen     = 0;
    start_i = 1; signed_i = s; a_i = a; b_i = b; annul_i = 0;
    t = cyc;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (sStall) stallCnt++;
      if (sReady) begin
        seen = 1;
        check({name, "_latency"}, 64'(sCyc - t), 64'(expLat));
        check({name, "_result"}, sRes, expRes);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_ready required=ready_within_60", name);
    end
    check({name, "_stallcycles"}, 64'(stallCnt), 64'(expLat));
    if (!hold) start_i = 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1; start_i = 0; signed_i = 0; a_i = '0; b_i = '0; annul_i = 0;
    @(posedge clk);
    cyc++;
    #1;
    step();
    check("reset_result", sRes, 64'h0);
    check("reset_busy", 64'(sBusy), 64'h0);
    rst = 0;

    check("model_divu_7_2", refDiv(0, 32'd7, 32'd2), {32'h1, 32'h3});
    check("model_div_ovf", refDiv(1, 32'h8000_0000, 32'hFFFF_FFFF), {32'h0, 32'h8000_0000});
    check("model_div_m7_2", refDiv(1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    runOp("divu_7_2", 0, 32'd7, 32'd2, {32'h1, 32'h3}, 33, 0);
    runOp("div_m7_2", 1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    runOp("div_7_m2", 1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33, 0);
    runOp("div_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 0);
    runOp("divu_ovf", 0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33, 0);
    runOp("divu_zero", 0, 32'h1234, 32'h0, {32'h1234, 32'hFFFF_FFFF}, 1, 0);
    step();

    // Annul part-way through an operation, then restart two cycles later.
    start_i = 1; signed_i = 0; a_i = 32'd100; b_i = 32'd7;
    repeat (10) step();
    annul_i = 1;
    step();
    check("annul_stall", 64'(sStall), 64'h0);
    check("annul_ready", 64'(sReady), 64'h0);
    annul_i = 0; start_i = 0;
    step();
    check("annul_idle_busy", 64'(sBusy), 64'h0);
    check("annul_result_held", sRes, {32'h1234, 32'hFFFF_FFFF});
    runOp("after_annul", 0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);

    // Reset mid-operation, then a held start followed by a back-to-back divide.
    start_i = 1; signed_i = 0; a_i = 32'd50; b_i = 32'd5;
    repeat (20) step();
    rst = 1; start_i = 0;
    step();
    rst = 0;
    step();
    check("rst_stall", 64'(sStall), 64'h0);
    check("rst_ready", 64'(sReady), 64'h0);
    check("rst_busy", 64'(sBusy), 64'h0);
    check("rst_result", sRes, 64'h0);
    runOp("post_rst", 0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1);
    runOp("back2back", 1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33, 0);

    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 999) == 0);
      annul_i = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) start_i = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) begin
        signed_i = 1'($urandom_range(0, 1));
        a_i      = pick();
        b_i      = pick();
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_div_ctrl
`default_nettype wire
